alu: RTL and testbench



---
 rtl/alu_if.sv | 47 ++++
 rtl/alu.sv | 154 +++++++++++++++
 tb/tb_alu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if
// Operand/result bundle for the registered ALU.
//   i_a, i_b    : unsigned operands (driven by the master)
//   i_carry     : borrow-in for the subtractor (driven by the master)
//   o_out_sub   : registered A - B - borrow-in, modulo 2^BITS
//   o_carry     : registered borrow-out of the subtraction
//   o_out_comp  : registered unsigned A > B
//   o_out_shl   : registered A << B
//   o_ERR_shl   : registered shift-amount-out-of-range flag
// The master drives the operands and observes the results; the slave (the
// ALU) consumes the operands and drives the results.
// ---------------------------------------------------------------------------
interface alu_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] i_a;
    logic [BITS-1:0] i_b;
    logic            i_carry;
    logic [BITS-1:0] o_out_sub;
    logic            o_carry;
    logic            o_out_comp;
    logic [BITS-1:0] o_out_shl;
    logic            o_ERR_shl;

    modport master (
        output i_a,
        output i_b,
        output i_carry,
        input  o_out_sub,
        input  o_carry,
        input  o_out_comp,
        input  o_out_shl,
        input  o_ERR_shl
    );

    modport slave (
        input  i_a,
        input  i_b,
        input  i_carry,
        output o_out_sub,
        output o_carry,
        output o_out_comp,
        output o_out_shl,
        output o_ERR_shl
    );
endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Registered arithmetic/logic unit. Every cycle it evaluates, in parallel:
//   - a subtract-with-borrow (ripple chain of 1-bit full subtractors),
//   - an unsigned greater-than compare (MSB-first scan),
//   - a logical left shift (log2(BITS)-stage barrel) with out-of-range flag.
// All results are captured on the rising clock edge (latency 1); the
// asynchronous active-low reset forces every output to zero immediately.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : alu_if slave modport (operands in, registered results out)
// ---------------------------------------------------------------------------
module alu #(
    parameter int BITS = 8
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    alu_if.slave   bus
);

    // Number of barrel stages; one stage per low bit of the shift amount.
    localparam int SH_W = (BITS > 1) ? $clog2(BITS) : 1;

    // BITS expressed on SH_W+1 bits, for the range check of the low
    // shift-amount bits when BITS is not a power of two.
    localparam logic [SH_W:0] BITS_LOW = (SH_W + 1)'(BITS);

    // ---------------------------------------------------------------------
    // Subtractor: ripple of 1-bit full subtractors, borrow moving upward.
    // ---------------------------------------------------------------------
    logic [BITS:0]   borrow_s;
    logic [BITS-1:0] diff_s;

    assign borrow_s[0] = bus.i_carry;

    genvar gi;
    generate
        for (gi = 0; gi < BITS; gi++) begin : g_fsub
            logic a_bit_s;
            logic b_bit_s;
            logic bin_s;

            assign a_bit_s = bus.i_a[gi];
            assign b_bit_s = bus.i_b[gi];
            assign bin_s   = borrow_s[gi];

            // Difference bit and borrow-out of a single full subtractor.
            assign diff_s[gi]     = a_bit_s ^ b_bit_s ^ bin_s;
            assign borrow_s[gi+1] = (~a_bit_s & b_bit_s) |
                                    (~(a_bit_s ^ b_bit_s) & bin_s);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Comparator: the first differing bit from the MSB decides A > B.
    // ---------------------------------------------------------------------
    logic comp_s;

    // Unsigned greater-than by MSB-first scan; equal operands leave it 0.
    always_comb begin
        logic decided_v;
        comp_s    = 1'b0;
        decided_v = 1'b0;
        for (int i = BITS - 1; i >= 0; i--) begin
            if (!decided_v && (bus.i_a[i] != bus.i_b[i])) begin
                comp_s    = bus.i_a[i];
                decided_v = 1'b1;
            end else begin
                comp_s    = comp_s;
                decided_v = decided_v;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Shifter: barrel stages driven by the low SH_W bits of i_b. Stage k
    // shifts by 2**k; since 2**k < BITS every slice below is non-empty.
    // ---------------------------------------------------------------------
    logic [BITS-1:0] stage_s [0:SH_W];

    assign stage_s[0] = bus.i_a;

    genvar gk;
    generate
        for (gk = 0; gk < SH_W; gk++) begin : g_shl
            localparam int SH = 2 ** gk;
            logic [BITS-1:0] shifted_s;

            assign shifted_s      = {stage_s[gk][BITS-1-SH:0], {SH{1'b0}}};
            assign stage_s[gk+1]  = bus.i_b[gk] ? shifted_s : stage_s[gk];
        end
    endgenerate

    // Range check: any set upper bit, or low bits already at/above BITS,
    // means the shift empties the word.
    logic            upper_set_s;
    logic            low_over_s;
    logic            err_s;
    logic [BITS-1:0] shl_s;

    generate
        if (BITS > SH_W) begin : g_upper
            assign upper_set_s = |bus.i_b[BITS-1:SH_W];
        end else begin : g_no_upper
            assign upper_set_s = 1'b0;
        end
    endgenerate

    assign low_over_s = ({1'b0, bus.i_b[SH_W-1:0]} >= BITS_LOW);
    assign err_s      = upper_set_s | low_over_s;

    // Out-of-range shifts produce zero instead of the wrapped barrel result.
    always_comb begin
        if (err_s) begin
            shl_s = {BITS{1'b0}};
        end else begin
            shl_s = stage_s[SH_W];
        end
    end

    // ---------------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------------
    logic [BITS-1:0] out_sub_r;
    logic            carry_r;
    logic            out_comp_r;
    logic [BITS-1:0] out_shl_r;
    logic            err_shl_r;

    // Capture all results each edge; reset clears them asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_sub_r  <= {BITS{1'b0}};
            carry_r    <= 1'b0;
            out_comp_r <= 1'b0;
            out_shl_r  <= {BITS{1'b0}};
            err_shl_r  <= 1'b0;
        end else begin
            out_sub_r  <= diff_s;
            carry_r    <= borrow_s[BITS];
            out_comp_r <= comp_s;
            out_shl_r  <= shl_s;
            err_shl_r  <= err_s;
        end
    end

    assign bus.o_out_sub  = out_sub_r;
    assign bus.o_carry    = carry_r;
    assign bus.o_out_comp = out_comp_r;
    assign bus.o_out_shl  = out_shl_r;
    assign bus.o_ERR_shl  = err_shl_r;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu (BITS = 8): directed cases plus randomized
// operands, compared against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu;

    localparam int BITS = 8;

    logic clk;
    logic rst_n;

    alu_if #(.BITS(BITS)) bus ();

    alu #(.BITS(BITS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int sub;
        int carry;
        int comp;
        int shl;
        int err;
    } exp_t;

    exp_t prev_e;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each function.
    function automatic exp_t model(input int a, input int b, input int cin);
        exp_t e;
        int   d;
        d       = a - b - cin;
        e.sub   = d & 255;
        e.carry = (d < 0) ? 1 : 0;
        e.comp  = (a > b) ? 1 : 0;
        e.shl   = (b < BITS) ? ((a << b) & 255) : 0;
        e.err   = (b >= BITS) ? 1 : 0;
        return e;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, ".sub"},   int'(bus.o_out_sub),  e.sub);
        check({tag, ".carry"}, int'(bus.o_carry),    e.carry);
        check({tag, ".comp"},  int'(bus.o_out_comp), e.comp);
        check({tag, ".shl"},   int'(bus.o_out_shl),  e.shl);
        check({tag, ".err"},   int'(bus.o_ERR_shl),  e.err);
    endtask

    // Called 1 time unit after a rising edge: drive, confirm outputs hold
    // until the next edge, then confirm the new result one edge later.
    task automatic apply(input string tag, input int a, input int b, input int cin);
        exp_t e;
        bus.i_a     = a[BITS-1:0];
        bus.i_b     = b[BITS-1:0];
        bus.i_carry = cin[0];
        e = model(a, b, cin);
        #2;
        check_outs({tag, ".hold"}, prev_e);
        @(posedge clk);
        #1;
        check_outs(tag, e);
        prev_e = e;
    endtask

    exp_t zero_e;

    initial begin
        zero_e  = '{0, 0, 0, 0, 0};
        rst_n   = 1'b1;
        bus.i_a = 8'hA5;
        bus.i_b = 8'h3C;
        bus.i_carry = 1'b1;

        // Reset asserted before any rising edge.
        #1 rst_n = 1'b0;
        #2;
        check_outs("reset", zero_e);
        prev_e = zero_e;

        @(posedge clk);
        #1;
        check_outs("reset_held", zero_e);
        rst_n = 1'b1;

        // Directed cases.
        apply("rel_10_5",    10,   5,    0);
        apply("borrow_oor",  8,    10,   0);
        apply("shift_eq8",   15,   8,    0);
        apply("shift3_cin",  1,    3,    1);
        apply("big_fe_fc",   'hFE, 'hFC, 0);
        apply("big_fc_fe",   'hFC, 'hFE, 0);
        apply("big_equal",   'hFE, 'hFE, 0);
        apply("zero_cin",    0,    0,    1);
        apply("msb_drop",    'h81, 7,    1);
        apply("ff_ff_cin",   'hFF, 'hFF, 1);
        apply("zero_shift",  'h5A, 0,    0);

        // Randomized back-to-back stream.
        for (int i = 0; i < 200; i++) begin
            int a;
            int b;
            int c;
            a = int'($urandom_range(255, 0));
            if ($urandom_range(1, 0) == 1) begin
                b = int'($urandom_range(10, 0));
            end else begin
                b = int'($urandom_range(255, 0));
            end
            c = int'($urandom_range(1, 0));
            apply("rand", a, b, c);
        end

        // Mid-stream reset between edges clears outputs immediately.
        apply("pre_rst", 'hC3, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        check_outs("mid_reset", zero_e);
        @(posedge clk);
        #1;
        check_outs("mid_reset_edge", zero_e);
        rst_n  = 1'b1;
        prev_e = zero_e;
        apply("post_rst", 'h33, 1, 1);
        apply("post_rst2", 'h07, 'h09, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
